gp9001_host_if: RTL and testbench

Host-side command port of the GP9001 video controller. It consumes the level-held operation strobes issued by the 68k bus decoder (`OP_*`) and the CPU write data. It executes register-select, register-write, VRAM-pointer-set, VRAM-write and VRAM-read operations against a 16-entry control register file and an arbitrated VRAM port. It returns read data and the completion acknowledge that releases the CPU's DTACK wait.

---
 rtl/gp9001_host_pkg.sv | 50 +++++
 rtl/gp9001_host_if_if.sv | 40 ++++
 rtl/gp9001_host_if_regfile.sv | 33 +++
 rtl/gp9001_host_if.sv | 136 +++++++++++++
 tb/tb_gp9001_host_if.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gp9001_host_pkg.sv
// Shared types for the GP9001 host command port: FSM states, op codes in priority order, default widths.
// Pure declarations; no latency or backpressure of its own.
package gp9001_host_pkg;

  localparam int DEF_AW     = 14;
  localparam int DEF_NREG_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT_GNT,
    ST_READ_CAP,
    ST_DONE
  } state_t;

  // Declaration order is the arbitration priority, highest first.
  typedef enum logic [2:0] {
    OPC_SET_RAM_PTR,
    OPC_SELECT_REG,
    OPC_WRITE_REG,
    OPC_WRITE_RAM,
    OPC_READ_RAM_L,
    OPC_READ_RAM_H,
    OPC_NONE
  } opc_t;

  typedef struct packed {
    logic set_ptr;
    logic select_reg;
    logic write_reg;
    logic write_ram;
    logic read_l;
    logic read_h;
  } op_req_t;

  function automatic opc_t op_pick(op_req_t r);
    if (r.set_ptr)         return OPC_SET_RAM_PTR;
    else if (r.select_reg) return OPC_SELECT_REG;
    else if (r.write_reg)  return OPC_WRITE_REG;
    else if (r.write_ram)  return OPC_WRITE_RAM;
    else if (r.read_l)     return OPC_READ_RAM_L;
    else if (r.read_h)     return OPC_READ_RAM_H;
    else                   return OPC_NONE;
  endfunction

  function automatic logic is_ram_op(opc_t o);
    return (o == OPC_WRITE_RAM) || (o == OPC_READ_RAM_L) || (o == OPC_READ_RAM_H);
  endfunction

endpackage

// File: rtl/gp9001_host_if_if.sv
// Bundle of CPU op strobes, VRAM port and renderer register read port for the GP9001 host side.
// slave = command port itself, master = CPU decoder / arbiter / renderer side.
interface gp9001_host_if_if
  import gp9001_host_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int NREG_W = DEF_NREG_W
);

  logic              OP_SELECT_REG;
  logic              OP_WRITE_REG;
  logic              OP_WRITE_RAM;
  logic              OP_READ_RAM_H;
  logic              OP_READ_RAM_L;
  logic              OP_SET_RAM_PTR;
  logic [15:0]       DIN;
  logic [15:0]       DOUT;
  logic              ACK;
  logic              VRAM_REQ;
  logic              VRAM_GNT;
  logic [AW-1:0]     VRAM_ADDR;
  logic              VRAM_WE;
  logic [15:0]       VRAM_WDATA;
  logic [15:0]       VRAM_RDATA;
  logic [NREG_W-1:0] REG_RADDR;
  logic [15:0]       REG_RDATA;

  modport slave (
    input  OP_SELECT_REG, OP_WRITE_REG, OP_WRITE_RAM, OP_READ_RAM_H, OP_READ_RAM_L,
    input  OP_SET_RAM_PTR, DIN, VRAM_GNT, VRAM_RDATA, REG_RADDR,
    output DOUT, ACK, VRAM_REQ, VRAM_ADDR, VRAM_WE, VRAM_WDATA, REG_RDATA
  );

  modport master (
    output OP_SELECT_REG, OP_WRITE_REG, OP_WRITE_RAM, OP_READ_RAM_H, OP_READ_RAM_L,
    output OP_SET_RAM_PTR, DIN, VRAM_GNT, VRAM_RDATA, REG_RADDR,
    input  DOUT, ACK, VRAM_REQ, VRAM_ADDR, VRAM_WE, VRAM_WDATA, REG_RDATA
  );

endinterface

// File: rtl/gp9001_host_if_regfile.sv
// Control register file: one write port addressed by the select register, one registered read port.
// Read latency 1 cycle, read-before-write on a colliding index; never stalls.
module gp9001_regfile #(
  parameter int NREG_W = 4
) (
  input  logic              CLK96,
  input  logic              RESET96n,
  input  logic              we,
  input  logic [NREG_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [NREG_W-1:0] raddr,
  output logic [15:0]       rdata
);

  localparam int NREG = 2 ** NREG_W;

  logic [15:0] regs [NREG];

  always_ff @(posedge CLK96 or negedge RESET96n) begin
    if (!RESET96n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        regs[waddr] <= wdata;
      end
      rdata <= regs[raddr];
    end
  end

endmodule

// File: rtl/gp9001_host_if.sv
// GP9001 host command port: executes CPU register/VRAM ops, ACK 2 cycles after sampling (EXEC) or after grant (+1 write, +2 read).
// Waits indefinitely for VRAM_GNT; holds ACK until every op strobe is low, accepting nothing new meanwhile.
module gp9001_host_if
  import gp9001_host_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int NREG_W = DEF_NREG_W
) (
  input  logic              CLK96,
  input  logic              RESET96n,
  gp9001_host_if_if.slave   bus
);

  state_t            state;
  state_t            state_nxt;
  opc_t              op_q;
  opc_t              op_sel;
  op_req_t           req;
  logic              any_op;
  logic [15:0]       din_q;
  logic [15:0]       dout_q;
  logic [AW-1:0]     ptr;
  logic [NREG_W-1:0] sel;
  logic              latch_op;
  logic              do_exec;
  logic              do_access;
  logic              do_cap;
  logic              ptr_inc;
  logic              reg_we;

  assign req = '{
    set_ptr:    bus.OP_SET_RAM_PTR,
    select_reg: bus.OP_SELECT_REG,
    write_reg:  bus.OP_WRITE_REG,
    write_ram:  bus.OP_WRITE_RAM,
    read_l:     bus.OP_READ_RAM_L,
    read_h:     bus.OP_READ_RAM_H
  };
  assign any_op = |req;
  assign op_sel = op_pick(req);

  always_ff @(posedge CLK96 or negedge RESET96n) begin
    if (!RESET96n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    latch_op  = 1'b0;
    do_exec   = 1'b0;
    do_access = 1'b0;
    do_cap    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_op) begin
          latch_op  = 1'b1;
          state_nxt = is_ram_op(op_sel) ? ST_WAIT_GNT : ST_EXEC;
        end
      end
      ST_EXEC: begin
        do_exec   = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_WAIT_GNT: begin
        if (bus.VRAM_GNT) begin
          do_access = 1'b1;
          state_nxt = (op_q == OPC_WRITE_RAM) ? ST_DONE : ST_READ_CAP;
        end
      end
      ST_READ_CAP: begin
        do_cap    = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!any_op) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // READ_RAM_H re-reads the same word so the high/low byte pair shares one address.
  assign ptr_inc = (do_access && (op_q == OPC_WRITE_RAM)) ||
                   (do_cap && (op_q == OPC_READ_RAM_L));
  assign reg_we  = do_exec && (op_q == OPC_WRITE_REG);

  always_ff @(posedge CLK96 or negedge RESET96n) begin
    if (!RESET96n) begin
      op_q   <= OPC_NONE;
      din_q  <= '0;
      dout_q <= '0;
      ptr    <= '0;
      sel    <= '0;
    end else begin
      if (latch_op) begin
        op_q  <= op_sel;
        din_q <= bus.DIN;
      end
      if (do_exec && (op_q == OPC_SET_RAM_PTR)) begin
        ptr <= din_q[AW-1:0];
      end else if (ptr_inc) begin
        ptr <= ptr + AW'(1);
      end
      if (do_exec && (op_q == OPC_SELECT_REG)) begin
        sel <= din_q[NREG_W-1:0];
      end
      if (do_cap) begin
        dout_q <= bus.VRAM_RDATA;
      end
    end
  end

  assign bus.ACK        = (state == ST_DONE);
  assign bus.VRAM_REQ   = (state == ST_WAIT_GNT);
  assign bus.VRAM_ADDR  = ptr;
  assign bus.VRAM_WE    = (state == ST_WAIT_GNT) && (op_q == OPC_WRITE_RAM) && bus.VRAM_GNT;
  assign bus.VRAM_WDATA = din_q;
  assign bus.DOUT       = dout_q;

  gp9001_regfile #(
    .NREG_W (NREG_W)
  ) u_regfile (
    .CLK96    (CLK96),
    .RESET96n (RESET96n),
    .we       (reg_we),
    .waddr    (sel),
    .wdata    (din_q),
    .raddr    (bus.REG_RADDR),
    .rdata    (bus.REG_RDATA)
  );

endmodule

// File: tb/tb_gp9001_host_if.sv
// Directed bench for gp9001_host_if with a behavioural VRAM behind the arbitrated port.
module tb_gp9001_host_if;

  localparam int AW     = 14;
  localparam int NREG_W = 4;

  localparam logic [5:0] M_SET  = 6'b100000;
  localparam logic [5:0] M_SEL  = 6'b010000;
  localparam logic [5:0] M_WREG = 6'b001000;
  localparam logic [5:0] M_WRAM = 6'b000100;
  localparam logic [5:0] M_RL   = 6'b000010;
  localparam logic [5:0] M_RH   = 6'b000001;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  int            checks   = 0;
  int            failures = 0;
  logic [15:0]   vram [2**AW];
  logic [15:0]   vram_rdata_q = '0;
  int            we_count = 0;
  int            we_base;
  logic [AW-1:0] last_we_addr = '0;

  gp9001_host_if_if #(.AW(AW), .NREG_W(NREG_W)) bus ();

  gp9001_host_if #(.AW(AW), .NREG_W(NREG_W)) dut (
    .CLK96    (clk),
    .RESET96n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  assign bus.VRAM_RDATA = vram_rdata_q;

  always @(posedge clk) begin
    if (bus.VRAM_REQ && bus.VRAM_GNT) begin
      if (bus.VRAM_WE) begin
        vram[bus.VRAM_ADDR] <= bus.VRAM_WDATA;
        we_count            <= we_count + 1;
        last_we_addr        <= bus.VRAM_ADDR;
      end
      vram_rdata_q <= vram[bus.VRAM_ADDR];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [5:0] m);
    bus.OP_SET_RAM_PTR = m[5];
    bus.OP_SELECT_REG  = m[4];
    bus.OP_WRITE_REG   = m[3];
    bus.OP_WRITE_RAM   = m[2];
    bus.OP_READ_RAM_L  = m[1];
    bus.OP_READ_RAM_H  = m[0];
  endtask

  task automatic drop_ops(input string tag);
    set_ops(6'b0);
    tick(1);
    chk(tag, 32'(bus.ACK), 32'h0);
  endtask

  task automatic run_exec(input string tag, input logic [5:0] m, input logic [15:0] d);
    set_ops(m);
    bus.DIN = d;
    tick(3);
    chk(tag, 32'(bus.ACK), 32'h1);
    drop_ops({tag, "_ackfall"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      vram[i] <= '0;
    end
    vram[14'h0100] <= 16'h55AA;
    vram[14'h0101] <= 16'h1357;
    set_ops(6'b0);
    bus.DIN       = '0;
    bus.VRAM_GNT  = 1'b0;
    bus.REG_RADDR = '0;
    rst_n         = 1'b0;
    tick(3);

    // Reset state
    chk("rst_ack",   32'(bus.ACK),        32'h0);
    chk("rst_req",   32'(bus.VRAM_REQ),   32'h0);
    chk("rst_we",    32'(bus.VRAM_WE),    32'h0);
    chk("rst_addr",  32'(bus.VRAM_ADDR),  32'h0);
    chk("rst_wdata", 32'(bus.VRAM_WDATA), 32'h0);
    chk("rst_dout",  32'(bus.DOUT),       32'h0);
    chk("rst_rdata", 32'(bus.REG_RDATA),  32'h0);
    rst_n = 1'b1;
    tick(2);

    // Pointer set, then a write lands at that pointer
    set_ops(M_SET);
    bus.DIN = 16'h1234;
    tick(1);
    chk("set_ack_early", 32'(bus.ACK), 32'h0);
    tick(2);
    chk("set_ack_edge2", 32'(bus.ACK), 32'h1);
    chk("set_no_req",    32'(bus.VRAM_REQ), 32'h0);
    drop_ops("set_ack_fall");
    tick(1);
    set_ops(M_WRAM);
    bus.DIN = 16'h0001;
    tick(2);
    chk("wr_req",      32'(bus.VRAM_REQ),  32'h1);
    chk("wr_addr",     32'(bus.VRAM_ADDR), 32'h1234);
    chk("wr_we_nognt", 32'(bus.VRAM_WE),   32'h0);
    chk("wr_wdata",    32'(bus.VRAM_WDATA), 32'h0001);
    bus.VRAM_GNT = 1'b1;
    #1;
    chk("wr_we_gnt", 32'(bus.VRAM_WE), 32'h1);
    tick(1);
    bus.VRAM_GNT = 1'b0;
    chk("wr_ack",     32'(bus.ACK),        32'h1);
    chk("wr_req_off", 32'(bus.VRAM_REQ),   32'h0);
    chk("wr_ptr_inc", 32'(bus.VRAM_ADDR),  32'h1235);
    chk("wr_mem",     32'(vram[14'h1234]), 32'h0001);
    drop_ops("wr_ack_fall");
    tick(1);

    // Register select + write; read-before-write on the renderer port
    run_exec("sel5", M_SEL, 16'h0005);
    tick(1);
    bus.REG_RADDR = 4'd5;
    set_ops(M_WREG);
    bus.DIN = 16'hBEEF;
    tick(2);
    chk("wreg_old_val", 32'(bus.REG_RDATA), 32'h0);
    tick(1);
    chk("wreg_new_val", 32'(bus.REG_RDATA), 32'hBEEF);
    chk("wreg_ack",     32'(bus.ACK),       32'h1);
    drop_ops("wreg_ack_fall");
    bus.REG_RADDR = 4'd4;
    tick(1);
    chk("reg4_zero", 32'(bus.REG_RDATA), 32'h0);
    bus.REG_RADDR = 4'd6;
    tick(1);
    chk("reg6_zero", 32'(bus.REG_RDATA), 32'h0);

    // Pointer wrap with a delayed grant
    run_exec("ptr3fff", M_SET, 16'h3FFF);
    tick(1);
    we_base = we_count;
    set_ops(M_WRAM);
    bus.DIN = 16'hA5A5;
    tick(1);
    tick(7);
    chk("wrap_req_wait", 32'(bus.VRAM_REQ), 32'h1);
    chk("wrap_no_we",    32'(we_count),     32'(we_base));
    bus.VRAM_GNT = 1'b1;
    tick(1);
    bus.VRAM_GNT = 1'b0;
    chk("wrap_we_once", 32'(we_count),         32'(we_base + 1));
    chk("wrap_we_addr", 32'(last_we_addr),     32'h3FFF);
    chk("wrap_mem",     32'(vram[14'h3FFF]),   32'hA5A5);
    chk("wrap_ptr0",    32'(bus.VRAM_ADDR),    32'h0);
    chk("wrap_ack",     32'(bus.ACK),          32'h1);
    tick(1);
    chk("wrap_hold_we", 32'(we_count), 32'(we_base + 1));
    chk("wrap_hold_ack", 32'(bus.ACK), 32'h1);
    drop_ops("wrap_ack_fall");
    tick(1);

    // Reads: H keeps the pointer, L advances it
    run_exec("ptr0100", M_SET, 16'h0100);
    tick(1);
    set_ops(M_RH);
    bus.VRAM_GNT = 1'b1;
    tick(2);
    chk("rh_ack_g1", 32'(bus.ACK), 32'h0);
    tick(1);
    chk("rh_ack_g2", 32'(bus.ACK),       32'h1);
    chk("rh_dout",   32'(bus.DOUT),      32'h55AA);
    chk("rh_ptr",    32'(bus.VRAM_ADDR), 32'h0100);
    drop_ops("rh_ack_fall");
    tick(1);
    set_ops(M_RL);
    tick(3);
    chk("rl_ack",  32'(bus.ACK),       32'h1);
    chk("rl_dout", 32'(bus.DOUT),      32'h55AA);
    chk("rl_ptr",  32'(bus.VRAM_ADDR), 32'h0101);
    drop_ops("rl_ack_fall");
    tick(1);
    set_ops(M_RH);
    tick(3);
    chk("rh2_dout", 32'(bus.DOUT),      32'h1357);
    chk("rh2_ptr",  32'(bus.VRAM_ADDR), 32'h0101);
    drop_ops("rh2_ack_fall");
    tick(1);

    // Simultaneous SET + WRITE_RAM: only SET runs, ACK holds until both drop
    we_base = we_count;
    set_ops(M_SET | M_WRAM);
    bus.DIN = 16'h0200;
    tick(3);
    chk("pri_ack",  32'(bus.ACK),       32'h1);
    chk("pri_ptr",  32'(bus.VRAM_ADDR), 32'h0200);
    chk("pri_req",  32'(bus.VRAM_REQ),  32'h0);
    tick(2);
    chk("pri_hold", 32'(bus.ACK),  32'h1);
    chk("pri_nowr", 32'(we_count), 32'(we_base));
    set_ops(M_WRAM);
    tick(1);
    chk("pri_one_high", 32'(bus.ACK), 32'h1);
    drop_ops("pri_ack_fall");
    tick(2);
    chk("pri_idle_req",  32'(bus.VRAM_REQ), 32'h0);
    chk("pri_idle_nowr", 32'(we_count),     32'(we_base));
    bus.VRAM_GNT = 1'b0;
    tick(1);

    // Asynchronous reset while waiting for grant
    we_base = we_count;
    set_ops(M_WRAM);
    bus.DIN = 16'hDEAD;
    tick(2);
    chk("ar_req_before", 32'(bus.VRAM_REQ), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(bus.VRAM_REQ),  32'h0);
    chk("ar_ack", 32'(bus.ACK),       32'h0);
    chk("ar_ptr", 32'(bus.VRAM_ADDR), 32'h0);
    set_ops(6'b0);
    tick(2);
    rst_n = 1'b1;
    bus.VRAM_GNT = 1'b1;
    bus.REG_RADDR = 4'd5;
    tick(4);
    chk("ar_no_wr",    32'(we_count),        32'(we_base));
    chk("ar_mem0",     32'(vram[14'h0000]),  32'h0);
    chk("ar_mem200",   32'(vram[14'h0200]),  32'h0);
    chk("ar_req_idle", 32'(bus.VRAM_REQ),    32'h0);
    chk("ar_reg5_clr", 32'(bus.REG_RDATA),   32'h0);
    bus.VRAM_GNT = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
